// File: rtl/mix_columns_seq_if.sv
// Handshake bundle between ShiftRows, the MixColumns unit and AddRoundKey.
// The master side is the upstream/downstream environment; the slave side is the unit.
interface mix_columns_seq_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_state;
    logic         in_inverse;
    logic         in_bypass;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_state;
    logic         busy;

    modport master (
        output in_valid, in_state, in_inverse, in_bypass, out_ready,
        input  in_ready, out_valid, out_state, busy
    );

    modport slave (
        input  in_valid, in_state, in_inverse, in_bypass, out_ready,
        output in_ready, out_valid, out_state, busy
    );
endinterface

// File: rtl/mix_columns_seq.sv
// Sequential AES MixColumns / InvMixColumns unit working on COLS_PER_CYCLE columns per clock.
// A state is latched on accept, transformed column group by column group, then held until taken.
module mix_columns_seq #(
    parameter int COLS_PER_CYCLE = 1
) (
    input logic            clk,
    input logic            rst_n,
    mix_columns_seq_if.slave bus
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // With four columns per cycle the step wraps to 0 and the first group is also the last.
    localparam logic [1:0] COL_STEP = 2'(COLS_PER_CYCLE);
    localparam logic [1:0] LAST_COL = 2'(4 - COLS_PER_CYCLE);

    logic [1:0]   state_q, state_d;
    logic [1:0]   col_cnt_q, col_cnt_d;
    logic [127:0] lat_state_q, lat_state_d;
    logic         lat_inverse_q, lat_inverse_d;
    logic         lat_bypass_q, lat_bypass_d;
    logic [127:0] out_state_q, out_state_d;
    logic [1:0]   col;
    logic         accept;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // Constant multiply built from reduced doublings, so every term stays in the field.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [3:0] k);
        logic [7:0] x2, x4, x8;
        x2 = xtime(a);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return (k[0] ? a : 8'h00) ^ (k[1] ? x2 : 8'h00) ^
               (k[2] ? x4 : 8'h00) ^ (k[3] ? x8 : 8'h00);
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] c, input logic inv,
                                            input logic byp);
        logic [7:0]  a [4];
        logic [7:0]  b [4];
        for (int r = 0; r < 4; r++) a[r] = c[31-8*r -: 8];
        for (int r = 0; r < 4; r++) begin
            if (inv)
                b[r] = gf_mul(a[r], 4'd14) ^ gf_mul(a[(r+1)%4], 4'd11) ^
                       gf_mul(a[(r+2)%4], 4'd13) ^ gf_mul(a[(r+3)%4], 4'd9);
            else
                b[r] = gf_mul(a[r], 4'd2) ^ gf_mul(a[(r+1)%4], 4'd3) ^
                       a[(r+2)%4] ^ a[(r+3)%4];
        end
        return byp ? c : {b[0], b[1], b[2], b[3]};
    endfunction

    assign accept = bus.in_valid && bus.in_ready;

    always_comb begin
        state_d       = state_q;
        col_cnt_d     = col_cnt_q;
        lat_state_d   = lat_state_q;
        lat_inverse_d = lat_inverse_q;
        lat_bypass_d  = lat_bypass_q;
        out_state_d   = out_state_q;
        col           = '0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    lat_state_d   = bus.in_state;
                    lat_inverse_d = bus.in_inverse;
                    lat_bypass_d  = bus.in_bypass;
                    col_cnt_d     = '0;
                    state_d       = S_BUSY;
                end
            end
            S_BUSY: begin
                for (int g = 0; g < COLS_PER_CYCLE; g++) begin
                    col = col_cnt_q + 2'(g);
                    out_state_d[32*(3-int'(col)) +: 32] =
                        mix_col(lat_state_q[32*(3-int'(col)) +: 32], lat_inverse_q, lat_bypass_q);
                end
                col_cnt_d = col_cnt_q + COL_STEP;
                if (col_cnt_q == LAST_COL) state_d = S_DONE;
            end
            S_DONE: begin
                if (bus.out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            col_cnt_q     <= '0;
            lat_state_q   <= '0;
            lat_inverse_q <= 1'b0;
            lat_bypass_q  <= 1'b0;
            out_state_q   <= '0;
        end else begin
            state_q       <= state_d;
            col_cnt_q     <= col_cnt_d;
            lat_state_q   <= lat_state_d;
            lat_inverse_q <= lat_inverse_d;
            lat_bypass_q  <= lat_bypass_d;
            out_state_q   <= out_state_d;
        end
    end

    // Outputs are gated by rst_n so nothing is flagged while reset is held.
    assign bus.in_ready  = (state_q == S_IDLE) && rst_n;
    assign bus.out_valid = (state_q == S_DONE) && rst_n;
    assign bus.busy      = ((state_q == S_BUSY) || (state_q == S_DONE)) && rst_n;
    assign bus.out_state = out_state_q;

endmodule
